// File: rtl/ddd_chain.sv
// ddd_chain: programs a daisy chain of 3D3444 serial delay chips, reads the chain back, and rewrites it on mismatch
module ddd_chain #(
    parameter int NCHIP = 2,
    parameter int DBITS = 4,
    parameter int MXPUP = 5,
    parameter int MXRETRY = 3,
    localparam int FBITS = 4 + 4*DBITS,
    localparam int NBITS = NCHIP*FBITS
) (
    input  logic                     clock,
    input  logic                     gbl_reset,
    input  logic                     power_up,
    input  logic                     start,
    input  logic                     autostart_en,
    input  logic [4*NCHIP-1:0]       oe,
    input  logic [4*DBITS*NCHIP-1:0] delay,
    output logic                     serial_clock,
    output logic                     serial_out,
    output logic                     adr_latch,
    input  logic                     serial_in,
    output logic                     busy,
    output logic                     verify_ok,
    output logic                     verify_err,
    output logic [2:0]               retry_cnt,
    output logic [NBITS-1:0]         readback
);
    localparam int CW = $clog2(NBITS);
    typedef enum logic [3:0] {
        st_wait_fpga, st_wait_powerup, st_idle, st_init, st_write,
        st_latch, st_verify, st_check, st_rewrite, st_unstart
    } state_t;
    state_t state, next;
    logic start_ff, clock_half, compare, sin_ff, exp_d1, exp_d2, sample;
    logic shifting, pass_end, load, cmp_ok, can_retry;
    logic [MXPUP-1:0] pup_cnt;
    logic [CW-1:0] bit_cnt;
    logic [NBITS-1:0] frame, sr;
    assign shifting = state == st_write || state == st_verify;
    assign pass_end = shifting && clock_half && bit_cnt == CW'(NBITS-1);
    assign load = state == st_init || state == st_rewrite || state == st_latch;
    assign cmp_ok = compare && !(sample && sin_ff != exp_d2);
    assign can_retry = retry_cnt < 3'(MXRETRY);
    assign busy = !(state == st_idle || state == st_wait_fpga);
    // frame[i] is the i-th bit on the wire: last chip first, oe[3:0] then ch0..ch3 MSB first
    always_comb begin
        frame = '0;
        for (int k = 0; k < NCHIP; k++) begin
            for (int j = 0; j < 4; j++)
                frame[(NCHIP-1-k)*FBITS + j] = oe[4*k+3-j];
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < DBITS; b++)
                    frame[(NCHIP-1-k)*FBITS + 4 + c*DBITS + b] = delay[(4*k+c)*DBITS + DBITS-1-b];
        end
    end
    always_comb begin
        next = state;
        case (state)
            st_wait_fpga:    next = power_up ? st_wait_powerup : st_wait_fpga;
            st_wait_powerup: next = &pup_cnt ? (autostart_en ? st_init : st_idle) : st_wait_powerup;
            st_idle:         next = start_ff ? st_init : st_idle;
            st_init:         next = st_write;
            st_rewrite:      next = st_write;
            st_write:        next = pass_end ? st_latch : st_write;
            st_latch:        next = st_verify;
            st_verify:       next = pass_end ? st_check : st_verify;
            st_check:        next = (!cmp_ok && can_retry) ? st_rewrite : st_unstart;
            st_unstart:      next = start_ff ? st_unstart : st_idle;
            default:         next = st_wait_fpga;
        endcase
    end
    // readback compare: serial_in is registered once, expected bit is delayed two clocks
    always_ff @(posedge clock) begin
        start_ff <= start && !gbl_reset;
        sin_ff <= serial_in;
        exp_d1 <= sr[0];
        exp_d2 <= exp_d1;
        if (gbl_reset || !power_up) begin
            state <= st_wait_fpga;
            pup_cnt <= '0;
            clock_half <= 1'b0;
            bit_cnt <= '0;
            sr <= '0;
            compare <= 1'b0;
            sample <= 1'b0;
            serial_clock <= 1'b0;
            serial_out <= 1'b0;
            adr_latch <= 1'b1;
        end else begin
            state <= next;
            pup_cnt <= state == st_wait_powerup ? pup_cnt + MXPUP'(1) : '0;
            clock_half <= shifting && !clock_half;
            bit_cnt <= load ? '0 : bit_cnt + CW'(shifting && clock_half);
            sr <= load ? frame : (shifting && clock_half) ? sr >> 1 : sr;
            compare <= state == st_init || state == st_rewrite || cmp_ok;
            sample <= state == st_verify && clock_half;
            serial_clock <= clock_half;
            serial_out <= shifting && sr[0];
            adr_latch <= state != st_latch;
        end
    end
    always_ff @(posedge clock) begin
        if (gbl_reset) begin
            verify_ok <= 1'b0;
            verify_err <= 1'b0;
            retry_cnt <= '0;
            readback <= '0;
        end else if (power_up) begin
            if (state == st_init)
                retry_cnt <= '0;
            else if (state == st_check && !cmp_ok && can_retry)
                retry_cnt <= retry_cnt + 3'd1;
            if (state == st_init || state == st_rewrite) begin
                verify_ok <= 1'b0;
                verify_err <= 1'b0;
            end else if (state == st_check) begin
                verify_ok <= cmp_ok;
                verify_err <= !cmp_ok && !can_retry;
            end
            if (sample)
                readback <= {sin_ff, readback[NBITS-1:1]};
        end
    end
endmodule
